// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - sequential single-precision accumulator that sums a stream of products.
// The datapath has one stage per state (align, add, normalize) and rounds by truncation.
module fp_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      prod,
    input  logic             prod_valid,
    input  logic             prod_last,
    output logic             prod_ready,
    output logic [31:0]      acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [CNT_W-1:0] term_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        op_q, op_d;
    logic               last_q, last_d;
    logic [7:0]         exp_q, exp_d;
    logic [23:0]        man_a_q, man_a_d;
    logic [23:0]        man_b_q, man_b_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [24:0]        sum_q, sum_d;
    logic               sign_q, sign_d;

    logic [23:0]        acc_man;
    logic [23:0]        op_man;
    logic [7:0]         diff;
    logic [4:0]         lz;
    logic [22:0]        frac_norm;
    logic [9:0]         e_norm;
    logic [31:0]        res;

    // Highest set bit wins because the loop runs from LSB upward.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        last_d    = last_q;
        exp_d     = exp_q;
        man_a_d   = man_a_q;
        man_b_d   = man_b_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        sum_d     = sum_q;
        sign_d    = sign_q;
        diff      = 8'd0;
        lz        = 5'd0;
        frac_norm = 23'd0;
        e_norm    = 10'd0;
        res       = 32'd0;

        // Exponent-zero words (zero and denormals) contribute a zero mantissa.
        acc_man = (acc_q[30:23] != 8'd0) ? {1'b1, acc_q[22:0]} : 24'd0;
        op_man  = (op_q[30:23]  != 8'd0) ? {1'b1, op_q[22:0]}  : 24'd0;

        case (state_q)
            IDLE: begin
                if (prod_valid) begin
                    op_d   = prod;
                    last_d = prod_last;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    state_d = ALIGN;
                end
            end

            ALIGN: begin
                sign_a_d = acc_q[31];
                sign_b_d = op_q[31];
                if (acc_q[30:23] >= op_q[30:23]) begin
                    exp_d   = acc_q[30:23];
                    diff    = acc_q[30:23] - op_q[30:23];
                    man_a_d = acc_man;
                    man_b_d = (diff >= 8'd24) ? 24'd0 : (op_man >> diff);
                end else begin
                    exp_d   = op_q[30:23];
                    diff    = op_q[30:23] - acc_q[30:23];
                    man_b_d = op_man;
                    man_a_d = (diff >= 8'd24) ? 24'd0 : (acc_man >> diff);
                end
                state_d = ADD;
            end

            ADD: begin
                if (sign_a_q == sign_b_q) begin
                    sum_d  = {1'b0, man_a_q} + {1'b0, man_b_q};
                    sign_d = sign_a_q;
                end else if (man_a_q >= man_b_q) begin
                    sum_d  = {1'b0, man_a_q - man_b_q};
                    sign_d = sign_a_q;
                end else begin
                    sum_d  = {1'b0, man_b_q - man_a_q};
                    sign_d = sign_b_q;
                end
                state_d = NORM;
            end

            NORM: begin
                if (sum_q[24]) begin
                    frac_norm = sum_q[23:1];
                    e_norm    = {2'b00, exp_q} + 10'd1;
                end else begin
                    // The leading one shifts out of the 23-bit field, leaving the fraction.
                    lz        = lzc24(sum_q[23:0]);
                    frac_norm = sum_q[22:0] << lz;
                    e_norm    = {2'b00, exp_q} - {5'd0, lz};
                end

                if (sum_q == 25'd0) begin
                    res = 32'd0;
                end else if (e_norm[9] || (e_norm == 10'd0)) begin
                    res = 32'd0;
                end else if (e_norm > 10'd254) begin
                    res = {sign_q, 8'hFF, 23'd0};
                end else begin
                    res = {sign_q, e_norm[7:0], frac_norm};
                end

                acc_d   = res;
                state_d = last_q ? DONE : IDLE;
            end

            DONE: begin
                if (acc_ready) begin
                    acc_d   = 32'd0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= 32'd0;
            cnt_q    <= '0;
            op_q     <= 32'd0;
            last_q   <= 1'b0;
            exp_q    <= 8'd0;
            man_a_q  <= 24'd0;
            man_b_q  <= 24'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sum_q    <= 25'd0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            last_q   <= last_d;
            exp_q    <= exp_d;
            man_a_q  <= man_a_d;
            man_b_q  <= man_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sum_q    <= sum_d;
            sign_q   <= sign_d;
        end
    end

    assign prod_ready = (state_q == IDLE);
    assign acc_valid  = (state_q == DONE);
    assign acc_out    = acc_q;
    assign term_count = cnt_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// tb/tb_fp_accumulator.sv - directed-vector bench for fp_accumulator.
module tb_fp_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] prod;
    logic        prod_valid;
    logic        prod_last;
    logic        prod_ready;
    logic [31:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic [15:0] term_count;

    int n_vec = 0;
    int n_err = 0;
    int w;

    always #5 clk = ~clk;

    fp_accumulator #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .term_count (term_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_acc_out"},    acc_out,             32'h0000_0000);
        check({tag, "_acc_valid"},  {31'd0, acc_valid},  32'd0);
        check({tag, "_prod_ready"}, {31'd0, prod_ready}, 32'd1);
        check({tag, "_term_count"}, {16'd0, term_count}, 32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [31:0] p, input logic l, output int waits);
        prod       = p;
        prod_last  = l;
        prod_valid = 1'b1;
        waits      = 0;
        while (!prod_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!prod_ready) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic expect_sum(input string tag, input logic [31:0] exp_acc, input int exp_cnt);
        int n;
        n = 1;
        while (!acc_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"},    n,                   32'd4);
        check({tag, "_acc_out"},    acc_out,             exp_acc);
        check({tag, "_term_count"}, {16'd0, term_count}, exp_cnt);
        check({tag, "_busy"},       {31'd0, prod_ready}, 32'd0);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        check_idle({tag, "_release"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        prod       = 32'd0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        acc_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1.0 + 2.0 = 3.0; second product is presented while busy and held
        send(32'h3F80_0000, 1'b0, w);
        send(32'h4000_0000, 1'b1, w);
        check("two_hold_cycles", w, 32'd3);
        expect_sum("two", 32'h4040_0000, 2);

        send(32'h3FC0_0000, 1'b0, w);
        send(32'hBFC0_0000, 1'b1, w);
        expect_sum("cancel", 32'h0000_0000, 2);

        send(32'h7F00_0000, 1'b0, w);
        send(32'h7F00_0000, 1'b1, w);
        expect_sum("overflow", 32'h7F80_0000, 2);

        // 3.0 - 2.5 = 0.5 needs a 2-bit left normalize
        send(32'h4040_0000, 1'b0, w);
        send(32'hC020_0000, 1'b1, w);
        expect_sum("renorm", 32'h3F00_0000, 2);

        // 2^-30 is 30 exponents below 1.0 and vanishes
        send(32'h3F80_0000, 1'b0, w);
        send(32'h3080_0000, 1'b1, w);
        expect_sum("far_shift", 32'h3F80_0000, 2);

        send(32'h0000_0000, 1'b1, w);
        expect_sum("zero_term", 32'h0000_0000, 1);

        send(32'h0040_0000, 1'b1, w);
        expect_sum("denormal", 32'h0000_0000, 1);

        // Backpressure: hold DONE for 5 cycles
        send(32'hC0A0_0000, 1'b1, w);
        begin
            int n;
            n = 1;
            while (!acc_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("bp_latency", n, 32'd4);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_acc_valid",  {31'd0, acc_valid},  32'd1);
            check("bp_acc_out",    acc_out,             32'hC0A0_0000);
            check("bp_term_count", {16'd0, term_count}, 32'd1);
            check("bp_prod_ready", {31'd0, prod_ready}, 32'd0);
            @(negedge clk);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        check_idle("bp_release");

        // Reset while in ALIGN discards the 2.0 operand
        send(32'h4000_0000, 1'b0, w);
        rst = 1'b1;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'h3F80_0000, 1'b1, w);
        expect_sum("after_reset", 32'h3F80_0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
